// File: rtl/sop_lut_seq_if.sv
// Bundle of the evaluation, serial-load and sweep signals of sop_lut_seq.
// master drives the inputs (software/bench side); slave is the function block.
interface sop_lut_seq_if #(
  parameter int unsigned N = 4
) ();
  logic [N-1:0] eval_in;
  logic         s;
  logic         load_en;
  logic         load_bit;
  logic         sweep_start;
  logic         sweep_busy;
  logic         sweep_valid;
  logic [N-1:0] sweep_idx;
  logic         sweep_s;
  logic         sweep_done;
  logic [N:0]   ones_count;

  modport master (
    output eval_in, load_en, load_bit, sweep_start,
    input  s, sweep_busy, sweep_valid, sweep_idx, sweep_s, sweep_done, ones_count
  );

  modport slave (
    input  eval_in, load_en, load_bit, sweep_start,
    output s, sweep_busy, sweep_valid, sweep_idx, sweep_s, sweep_done, ones_count
  );
endinterface

// File: rtl/sop_lut_seq.sv
// N-input Boolean function held in a serially reloadable truth table, with a registered
// evaluation output and a sweep engine that streams every minterm and counts the ones.
module sop_lut_seq #(
  parameter int unsigned         N    = 4,
  parameter logic [(2**N)-1:0]   INIT = 16'h7310
) (
  input logic          clk,
  input logic          rst_n,
  sop_lut_seq_if.slave bus
);
  localparam int unsigned  Size    = 2 ** N;
  localparam logic [N-1:0] LastIdx = N'(Size - 1);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e            state_q, state_d;
  logic [Size-1:0]   tbl_q, tbl_d;
  logic [N-1:0]      idx_q, idx_d;
  logic [N:0]        cnt_q, cnt_d;
  logic              s_q;

  always_comb begin
    state_d = state_q;
    tbl_d   = tbl_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // A start beats a simultaneous load: no shift on that edge.
        if (bus.sweep_start) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StSweep;
        end else if (bus.load_en) begin
          tbl_d = {bus.load_bit, tbl_q[Size-1:1]};
        end
      end
      StSweep: begin
        cnt_d = cnt_q + {{N{1'b0}}, tbl_q[idx_q]};
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tbl_q   <= INIT;
      idx_q   <= '0;
      cnt_q   <= '0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      s_q     <= tbl_q[bus.eval_in];
    end
  end

  always_comb begin
    bus.s           = s_q;
    bus.sweep_busy  = (state_q == StSweep);
    bus.sweep_valid = (state_q == StSweep);
    bus.sweep_idx   = (state_q == StSweep) ? idx_q : '0;
    bus.sweep_s     = (state_q == StSweep) & tbl_q[idx_q];
    bus.sweep_done  = (state_q == StDone);
    bus.ones_count  = cnt_q;
  end
endmodule

// File: doc/sop_lut_seq.md
Name: sop_lut_seq

Overview:
- Parametrised, clocked successor to the fixed 4-input sum-of-products function block.
- The Boolean function of N inputs is held in a 2^N-bit truth-table register. Reset loads the table from a parameter; software can reload it serially.
- Evaluation output is registered.
- A built-in sweep engine walks every minterm in order, streams each result, and counts the ones. Benches and self-test use it to check the whole truth table.

Parameters:
- N, 4, number of function inputs (1..8).
- INIT, 16'h7310, reset truth table; bit k = f(k) with k = {a,b,c,d} packed MSB-first. Default equals s = 1 for minterms 4, 8, 9, 12, 13, 14. Width is 2^N.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- eval_in  in  N  input vector to evaluate.
- s  out  1  registered f(eval_in).
- load_en  in  1  shift one truth-table bit this cycle.
- load_bit  in  1  serial truth-table bit; minterm 0 is sent first.
- sweep_start  in  1  start a full-table sweep (level-sampled).
- sweep_busy  out  1  high while in SWEEP.
- sweep_valid  out  1  sweep_idx/sweep_s valid this cycle (= sweep_busy).
- sweep_idx  out  N  minterm currently being reported.
- sweep_s  out  1  table[sweep_idx].
- sweep_done  out  1  one-cycle pulse after the last minterm.
- ones_count  out  N+1  number of ones found by the sweep.

Behaviour:
- Reset (rst_n=0 at edge):
  - table <= INIT; s <= 0; state <= IDLE; idx <= 0; ones_count <= 0.
  - Reset overrides every other input, including mid-sweep and mid-load.
- Eval path, active in all states:
  - At each edge, s <= table[eval_in], using the table value from before any shift at that same edge.
  - Latency is 1 cycle.
- Load (IDLE only):
  - On load_en=1, table <= {load_bit, table[2^N-1:1]}.
  - After exactly 2^N consecutive loads, the first bit sent sits at index 0.
  - A partial load leaves a partially shifted table; there is no error flag.
  - load_en is ignored in SWEEP and DONE.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE: if sweep_start=1, then idx <= 0, ones_count <= 0, and go to SWEEP. If sweep_start and load_en are both 1, the sweep wins and no shift occurs.
  - SWEEP: sweep_valid=1; sweep_idx=idx; sweep_s=table[idx] (combinational from registers). Each edge does ones_count <= ones_count + table[idx]. If idx == 2^N-1, go to DONE; else idx <= idx+1.
  - DONE: sweep_done=1 for exactly one cycle; ones_count already holds the final sum; go to IDLE.
- Sweep timing:
  - A start sampled at edge E gives SWEEP cycles E+1 .. E+2^N, DONE at cycle E+2^N+1, and IDLE afterwards.
  - sweep_start is ignored while in SWEEP or DONE.
- Outputs held between sweeps:
  - ones_count holds its value until the next accepted sweep_start.
  - In IDLE and DONE: sweep_idx=0, sweep_s=0, sweep_valid=0.
- Width rules:
  - ones_count is N+1 bits, so an all-ones table gives 2^N with no overflow.
  - idx does not wrap inside a sweep; termination is by comparison with 2^N-1.
- Reset mid-sweep: the sweep aborts immediately, no done pulse is emitted, and ones_count=0 and the table=INIT in the following cycle.

Test Plan:
- Reset, then sweep_start for 1 cycle -> sweep_valid high for 16 cycles; sweep_s=1 exactly at idx 4, 8, 9, 12, 13, 14; sweep_done pulses at start+17; ones_count=6.
- Drive eval_in=4'b1100 then 4'b0011 after reset -> s=1, then s=0, each one cycle after the input is applied. Exhaustive eval_in 0..15 must match the sweep_s sequence.
- Load 16 ones, then sweep -> ones_count=5'd16 (boundary). Load 16 zeros, then sweep -> ones_count=0 and sweep_s never high.
- Load pattern 16'h8001 (bit0 first), then hold load_en=1 and pulse sweep_start in the same cycle -> no shift occurs; sweep reports 1 at idx 0 and 15 only; ones_count=2. Toggling load_en during the sweep leaves the table unchanged.
- Start a sweep, assert rst_n=0 at idx=7 -> next cycle sweep_busy=0, ones_count=0, no sweep_done. A new sweep reports INIT again (count 6).
- N=3, INIT=8'b1110_1000 instance -> sweep length 8, done at start+9, ones_count=4'd4.
